// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and types for the seven-segment scan controller.
//   CODE_W      width of the code handed to the cathode decoder
//   CODE_P      decoder code for the letter 'p'
//   CODE_DASH   decoder code for '-', shown while no word has been loaded
//   scan_state_e  EMPTY (showing "----") / RUN (showing a committed word)
//   digit_idx_t   2-bit scan position, 0 = rightmost digit
package seg_pkg;

  localparam int                CODE_W    = 5;
  localparam logic [CODE_W-1:0] CODE_P    = 5'h10;
  localparam logic [CODE_W-1:0] CODE_DASH = 5'h11;
  localparam int                N_DIGITS  = 4;

  typedef enum logic [0:0] {
    SCAN_EMPTY = 1'b0,
    SCAN_RUN   = 1'b1
  } scan_state_e;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode pattern for a scan position.
  function automatic logic [N_DIGITS-1:0] anode_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if -- valid/ready load channel into the scan controller.
//   in_data   16-bit word, four hex nibbles, [3:0] = rightmost digit
//   in_valid  producer offers in_data
//   in_ready  controller can take a word (no word pending)
// Modports: master = producer side, slave = seg_scan_ctrl side.
interface seg_scan_ctrl_if;

  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/seg_prescaler.sv
// seg_prescaler -- slot timer for the digit scan.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   o_tick  high during the last cycle of each CLK_DIV-cycle slot
// Parameter CLK_DIV: clk cycles per digit slot (>= 2).
module seg_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int               CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- four-digit multiplexed display scan controller.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         load channel (seg_scan_ctrl_if.slave): in_data/in_valid/in_ready
//   disp_en     1 = display lit, 0 = all anodes off (scan keeps running)
//   digit_code  code for the external cathode decoder (0x0-0xF, 0x10 'p', 0x11 '-')
//   anode       one-hot active-low digit enable
//   frame_tick  one-cycle pulse in the first cycle of each new frame
// Optional build macro LEADING_ZERO_BLANK_EN: once a word is shown, digits
// that are zero together with every digit to their left stay dark
// (digit 0 always lights).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_ctrl_if.slave     bus,
  input  logic               disp_en,
  output logic [CODE_W-1:0]  digit_code,
  output logic [3:0]         anode,
  output logic               frame_tick
);

  localparam logic [0:0] S_EMPTY = 1'(SCAN_EMPTY);
  localparam logic [0:0] S_RUN   = 1'(SCAN_RUN);

  logic                        w_tick;
  logic                        w_wrap;
  logic                        w_commit;
  logic                        w_accept;
  digit_idx_t                  r_idx;
  digit_idx_t                  w_idx_next;
  logic                        r_pending;
  logic [15:0]                 r_pend_data;
  logic [0:0]                  r_state;
  logic [0:0]                  w_state_next;
  logic [3:0][CODE_W-1:0]      r_shadow;
  logic [3:0][CODE_W-1:0]      w_shadow_next;
  logic [3:0]                  w_blank;
  logic [3:0]                  w_anode_next;
  logic [CODE_W-1:0]           w_code_next;
  logic [3:0]                  r_anode;
  logic [CODE_W-1:0]           r_code;
  logic                        r_frame_tick;

  seg_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // Frame boundary: the slot tick that moves the scan from digit 3 to 0.
  // Committing only here keeps every frame showing a single word.
  assign w_wrap   = w_tick && (r_idx == 2'd3);
  assign w_commit = w_wrap && r_pending;
  assign w_accept = bus.in_valid && !r_pending;

  assign bus.in_ready = ~r_pending;

  assign w_idx_next   = w_tick ? digit_idx_t'(r_idx + 2'd1) : r_idx;
  assign w_state_next = w_commit ? S_RUN : r_state;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_shadow
    assign w_shadow_next[gi] = w_commit ? {1'b0, r_pend_data[4*gi +: 4]}
                                        : r_shadow[gi];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] w_zero;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_zero
    assign w_zero[gi] = (w_shadow_next[gi] == '0);
  end

  assign w_blank[0] = 1'b0;
  for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_blank
    assign w_blank[gi] = (w_state_next == S_RUN) && (&w_zero[3:gi]);
  end
`else
  assign w_blank = '0;
`endif

  // Outputs are registered from next-state values so anode, code and the
  // shadow contents all switch on the same edge as the scan index.
  assign w_anode_next = disp_en ? (anode_sel(w_idx_next) | w_blank) : 4'hF;
  assign w_code_next  = (w_state_next == S_EMPTY) ? CODE_DASH
                                                  : w_shadow_next[w_idx_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_pend_data  <= '0;
      r_state      <= S_EMPTY;
      r_shadow     <= {N_DIGITS{CODE_DASH}};
      r_anode      <= 4'hF;
      r_code       <= CODE_DASH;
      r_frame_tick <= 1'b0;
    end else begin
      r_idx <= w_idx_next;
      if (w_accept) begin
        r_pending   <= 1'b1;
        r_pend_data <= bus.in_data;
      end else if (w_commit) begin
        r_pending   <= 1'b0;
      end
      r_state      <= w_state_next;
      r_shadow     <= w_shadow_next;
      r_anode      <= w_anode_next;
      r_code       <= w_code_next;
      r_frame_tick <= w_wrap;
    end
  end

  assign anode      = r_anode;
  assign digit_code = r_code;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: CLK_DIV, 50000, clk cycles per digit slot (>=2).
REQ-002 Port: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_data  input  16  four hex nibbles, [3:0] = digit 0 (rightmost).
REQ-005 Port: in_valid  input  1  in_data offered.
REQ-006 Port: in_ready  output  1  controller can accept in_data.
REQ-007 Port: disp_en  input  1  1 = display lit, 0 = all anodes off.
REQ-008 Port: digit_code  output  5  code to the cathode decoder: 0x00-0x0F hex, 0x10 'p', 0x11 '-'.
REQ-009 Port: anode  output  4  one-hot active-low digit enable.
REQ-010 Port: frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-011 Prescaler counts 0..CLK_DIV-1, then wraps to 0; the terminal count is the slot tick.
REQ-012 Scan index (2 bits) advances 0->1->2->3->0 on each slot tick.
REQ-013 anode = ~(1 << index) when disp_en=1, else 4'b1111; index and prescaler keep running with disp_en=0.
REQ-014 digit_code = shadow[index] (5-bit), registered, changing in the same cycle as anode.
REQ-015 Handshake: transfer when in_valid & in_ready; accepted word goes to a pending register, pending flag set.
REQ-016 in_ready = ~pending; in_data need not be held after the transfer cycle.
REQ-017 Commit: on the slot tick with index=3 and pending set, shadow <= {1'b0, nibbles}, pending cleared, in_ready high next cycle.
REQ-018 Display never changes mid-frame (no tearing); latency from accept to visible is at most one full frame + 1 slot.
REQ-019 FSM states: EMPTY (shadow all 0x11, shows "----") and RUN; EMPTY->RUN on the first commit; RUN is terminal until reset.
REQ-020 frame_tick asserts in the cycle the index goes from 3 to 0, whether or not a commit occurs.
REQ-021 Accepting a transfer in the commit cycle is impossible: in_ready is low while pending is set.

Reset
REQ-022 rst_n low: prescaler=0, index=0, pending=0, state=EMPTY, shadow=all 0x11.
REQ-023 Reset outputs: anode=4'b1111, digit_code=5'h11, in_ready=1, frame_tick=0.
REQ-024 Reset mid-frame or with pending set discards the pending word; no commit after release.
REQ-025 First slot tick after release: index=1 (digit 0 is shown during the first slot).

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN: when defined, in RUN the anode of a digit is forced high if that digit and all digits to its left are 0x0; digit 0 is never blanked.
REQ-027 When the macro is not defined, all four digits always light according to disp_en.

Structure
REQ-028 Package seg_pkg: CODE_W=5, CODE_P=5'h10, CODE_DASH=5'h11, the scan FSM state enum and the digit-index type.
REQ-029 One sub-module, seg_prescaler (counter + slot tick, parameter CLK_DIV); everything else is in seg_scan_ctrl.
REQ-030 digit_code feeds the existing cathode decoder outside this block; this block does not decode segments.

Verification (CLK_DIV=4)
REQ-031 Reset release with no load -> anode cycles 1110,1101,1011,0111 every 4 clks; digit_code=0x11 throughout.
REQ-032 Load 16'h12AF mid-frame -> in_ready low next cycle; after the next 3->0 wrap, the anode/code pairs read digit0=0xF, digit1=0xA, digit2=0x2, digit3=0x1; in_ready high again.
REQ-033 Hold in_valid with 16'h0001 then 16'h0002 back-to-back -> second word stalls until the first commits; the frame sequence shows ...0001 then ...0002, with no mixed frame.
REQ-034 disp_en=0 for 10 clks -> anode=1111, frame_tick period is still 16 clks, and index continues from the expected slot on re-enable.
REQ-035 Assert rst_n low while pending 16'hBEEF -> outputs return to the reset values; after release, "----" is shown and BEEF never appears.
REQ-036 With LEADING_ZERO_BLANK_EN defined, load 16'h0040 -> digits 3 and 2 anode stay high, digits 1 and 0 light (codes 0x4, 0x0); load 16'h0000 -> only digit 0 lights.
